d_latch_checker: RTL and testbench
==================================

D_LATCH_CHECKER -- requirements
Module: d_latch_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: stable cycles required after any observed input change before comparing; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error and check counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset of the checker.
REQ-005 SHALL have port obs_rstn, input, 1: observed latch reset, active-low.
REQ-006 SHALL have port obs_en, input, 1: observed latch enable.
REQ-007 SHALL have port obs_d, input, 1: observed latch data.
REQ-008 SHALL have port obs_q, input, 1: observed latch output.
REQ-009 SHALL have port clr, input, 1: synchronous clear of err_sticky, err_cnt and chk_cnt.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per detected mismatch.
REQ-011 SHALL have port err_sticky, output, 1: set on any mismatch; held until clr or reset.
REQ-012 SHALL have port err_cnt, output, CNT_W: saturating mismatch count.
REQ-013 SHALL have port chk_cnt, output, CNT_W: saturating count of stable intervals checked.
REQ-014 SHALL have port exp_q, output, 1: reference-model latch value.

Function
REQ-015 SHALL register obs_rstn, obs_en, obs_d and obs_q through one sample stage (s_*) before any use.
REQ-016 SHALL update exp_q each cycle: 0 if s_rstn=0; else s_d if s_en=1; else hold.
REQ-017 SHALL flag a change when any of s_rstn, s_en or s_d differs from its previous-cycle value; a change in s_q alone SHALL NOT count as a change.
REQ-018 SHALL implement FSM states SETTLE, CHECK and FLAGGED.
REQ-019 SETTLE: timer loaded with SETTLE_CYC on entry and on every change; decrements each change-free cycle; at 0 -> CHECK, and chk_cnt increments by 1 on that transition.
REQ-020 CHECK: s_q compared to exp_q every cycle; mismatch -> err=1 for that cycle, err_cnt+1, err_sticky=1, next state FLAGGED.
REQ-021 FLAGGED: no further comparisons; remains until a change occurs -> SETTLE, so at most one error is reported per stable interval.
REQ-022 A change in CHECK or FLAGGED SHALL send the FSM to SETTLE; a change and a mismatch in the same cycle SHALL count as a change only, with no error.
REQ-023 err_cnt and chk_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clr SHALL zero err_sticky, err_cnt and chk_cnt; an error or check event in the same cycle SHALL be applied after the clear (result 1).
REQ-025 clr SHALL NOT affect FSM state, timer or exp_q.

Reset
REQ-026 While rstn=0, outputs SHALL be: err=0, err_sticky=0, err_cnt=0, chk_cnt=0, exp_q=0; sample regs=0; FSM=SETTLE; timer=SETTLE_CYC.
REQ-027 Reset assertion mid-interval SHALL abandon the interval without an error pulse or count.

Configuration
REQ-028 With macro D_LATCH_CHECKER_SYNC_EN defined, each observed input SHALL pass a 2-flop synchronizer ahead of the sample stage, adding 2 cycles of latency to all responses.
REQ-029 Without D_LATCH_CHECKER_SYNC_EN, only the single sample stage of REQ-015 SHALL exist.

Verification (SETTLE_CYC=2, CNT_W=8, macro undefined)
REQ-030 Reset: rstn=0 then released, obs_* held at 0 -> exp_q=0, err never pulses, chk_cnt=1 after 3 cycles.
REQ-031 Transparency: obs_en=1, obs_d 0->1, obs_q follows within 1 cycle -> exp_q=1, no err, chk_cnt increments once.
REQ-032 Hold fault: obs_en=0, obs_d toggles, obs_q toggles with it -> exactly one err pulse per stable interval; err_sticky=1; err_cnt=1 after the first interval.
REQ-033 Settle masking: obs_q lags obs_d by 2 cycles with obs_en=1 -> no err; with a lag of 4 cycles -> one err.
REQ-034 Saturation/clear: force 300 mismatched intervals -> err_cnt=255; clr pulse -> err_cnt=0, err_sticky=0; clr coincident with an error -> err_cnt=1.
REQ-035 Async reset mid-CHECK with obs_q wrong -> no err pulse; all outputs 0 per REQ-026.

Source files
------------

// File: rtl/d_latch_checker.sv
// Cycle-based reference checker for an observed level-sensitive D latch with active-low reset.
// Optional macro D_LATCH_CHECKER_SYNC_EN adds a 2-flop synchronizer on every observed input.
module d_latch_checker #(
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             obs_rstn,
   input  logic             obs_en,
   input  logic             obs_d,
   input  logic             obs_q,
   input  logic             clr,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic             exp_q
);

   localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CHECK   = 2'd1,
      FLAGGED = 2'd2
   } state_t;

   // Clear takes effect first, so an event in the clear cycle lands on zero.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             clear,
                                                 input logic             inc);
      logic [CNT_W-1:0] base;
      base = clear ? {CNT_W{1'b0}} : cnt;
      if (inc && (base != CNT_MAX)) begin
         cnt_next = base + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_next = base;
      end
   endfunction

   logic in_rstn_s, in_en_s, in_d_s, in_q_s;

`ifdef D_LATCH_CHECKER_SYNC_EN
   logic [3:0] sync1_r, sync2_r;

   // Two-flop synchronizer for the asynchronous observed signals.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= {obs_rstn, obs_en, obs_d, obs_q};
         sync2_r <= sync1_r;
      end
   end

   assign {in_rstn_s, in_en_s, in_d_s, in_q_s} = sync2_r;
`else
   assign {in_rstn_s, in_en_s, in_d_s, in_q_s} = {obs_rstn, obs_en, obs_d, obs_q};
`endif

   logic s_rstn_r, s_en_r, s_d_r, s_q_r;
   logic p_rstn_r, p_en_r, p_d_r;
   logic exp_q_r;
   logic change_s, mismatch_s;

   // Sample stage plus a one-cycle history of the latch controls for change detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_rstn_r <= 1'b0;
         s_en_r   <= 1'b0;
         s_d_r    <= 1'b0;
         s_q_r    <= 1'b0;
         p_rstn_r <= 1'b0;
         p_en_r   <= 1'b0;
         p_d_r    <= 1'b0;
      end else begin
         s_rstn_r <= in_rstn_s;
         s_en_r   <= in_en_s;
         s_d_r    <= in_d_s;
         s_q_r    <= in_q_s;
         p_rstn_r <= s_rstn_r;
         p_en_r   <= s_en_r;
         p_d_r    <= s_d_r;
      end
   end

   // Reference latch model driven from the sampled controls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q_r <= 1'b0;
      end else if (!s_rstn_r) begin
         exp_q_r <= 1'b0;
      end else if (s_en_r) begin
         exp_q_r <= s_d_r;
      end else begin
         exp_q_r <= exp_q_r;
      end
   end

   // The observed output alone never restarts settling; only the latch controls do.
   assign change_s   = (s_rstn_r ^ p_rstn_r) | (s_en_r ^ p_en_r) | (s_d_r ^ p_d_r);
   assign mismatch_s = s_q_r ^ exp_q_r;

   state_t     state_r, state_nxt_s;
   logic [3:0] timer_r, timer_nxt_s;
   logic       chk_ev_s, err_ev_s;

   // FSM state and settle timer register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= SETTLE;
         timer_r <= SETTLE_LD;
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
      end
   end

   // Next-state logic: a change always wins over a same-cycle mismatch.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      chk_ev_s    = 1'b0;
      err_ev_s    = 1'b0;
      case (state_r)
         SETTLE: begin
            if (change_s) begin
               timer_nxt_s = SETTLE_LD;
            end else if (timer_r <= 4'd1) begin
               state_nxt_s = CHECK;
               timer_nxt_s = 4'd0;
               chk_ev_s    = 1'b1;
            end else begin
               timer_nxt_s = timer_r - 4'd1;
            end
         end
         CHECK: begin
            if (change_s) begin
               state_nxt_s = SETTLE;
               timer_nxt_s = SETTLE_LD;
            end else if (mismatch_s) begin
               state_nxt_s = FLAGGED;
               err_ev_s    = 1'b1;
            end else begin
               state_nxt_s = CHECK;
            end
         end
         FLAGGED: begin
            if (change_s) begin
               state_nxt_s = SETTLE;
               timer_nxt_s = SETTLE_LD;
            end else begin
               state_nxt_s = FLAGGED;
            end
         end
         default: begin
            state_nxt_s = SETTLE;
            timer_nxt_s = SETTLE_LD;
         end
      endcase
   end

   logic             err_r, err_sticky_r;
   logic [CNT_W-1:0] err_cnt_r, chk_cnt_r;

   // Registered error pulse, sticky flag and saturating counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_r        <= 1'b0;
         err_sticky_r <= 1'b0;
         err_cnt_r    <= {CNT_W{1'b0}};
         chk_cnt_r    <= {CNT_W{1'b0}};
      end else begin
         err_r        <= err_ev_s;
         err_sticky_r <= err_ev_s | (~clr & err_sticky_r);
         err_cnt_r    <= cnt_next(err_cnt_r, clr, err_ev_s);
         chk_cnt_r    <= cnt_next(chk_cnt_r, clr, chk_ev_s);
      end
   end

   assign err        = err_r;
   assign err_sticky = err_sticky_r;
   assign err_cnt    = err_cnt_r;
   assign chk_cnt    = chk_cnt_r;
   assign exp_q      = exp_q_r;

endmodule

// File: tb/tb_d_latch_checker.sv
// Directed bench for d_latch_checker (SETTLE_CYC=2, CNT_W=8); expectations are hand-derived.
module tb_d_latch_checker;

   logic       clk = 1'b0;
   logic       rstn, obs_rstn, obs_en, obs_d, obs_q, clr;
   logic       err, err_sticky, exp_q;
   logic [7:0] err_cnt, chk_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int err_pulses  = 0;

   d_latch_checker #(.SETTLE_CYC(2), .CNT_W(8)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .obs_rstn   (obs_rstn),
      .obs_en     (obs_en),
      .obs_d      (obs_d),
      .obs_q      (obs_q),
      .clr        (clr),
      .err        (err),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt),
      .chk_cnt    (chk_cnt),
      .exp_q      (exp_q)
   );

   always #5 clk = ~clk;

   // Count every err pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (err === 1'b1) err_pulses++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   initial begin
      rstn = 1'b0; obs_rstn = 1'b0; obs_en = 1'b0; obs_d = 1'b0; obs_q = 1'b0; clr = 1'b0;
      tick(3);
      check("rst_err", err, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_chk_cnt", chk_cnt, 0);
      check("rst_exp_q", exp_q, 0);

      // Release with everything idle: first check completes two edges later.
      rstn = 1'b1;
      tick(3);
      check("rel_chk_cnt", chk_cnt, 1);
      check("rel_exp_q", exp_q, 0);
      check("rel_pulses", err_pulses, 0);

      // Transparent latch tracking d.
      obs_rstn = 1'b1; obs_en = 1'b1;
      tick(6);
      check("en_chk_cnt", chk_cnt, 2);
      obs_d = 1'b1;
      tick(1);
      obs_q = 1'b1;
      tick(6);
      check("transp_exp_q", exp_q, 1);
      check("transp_chk_cnt", chk_cnt, 3);
      check("transp_pulses", err_pulses, 0);

      // q lags d by 2 cycles: masked by settling.
      obs_d = 1'b0;
      tick(2);
      obs_q = 1'b0;
      tick(6);
      check("lag2_exp_q", exp_q, 0);
      check("lag2_chk_cnt", chk_cnt, 4);
      check("lag2_pulses", err_pulses, 0);

      // q lags d by 4 cycles: one error.
      obs_d = 1'b1;
      tick(4);
      obs_q = 1'b1;
      tick(6);
      check("lag4_chk_cnt", chk_cnt, 5);
      check("lag4_pulses", err_pulses, 1);
      check("lag4_err_cnt", err_cnt, 1);
      check("lag4_sticky", err_sticky, 1);

      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr1_err_cnt", err_cnt, 0);
      check("clr1_sticky", err_sticky, 0);
      check("clr1_chk_cnt", chk_cnt, 0);

      // Hold fault: latch closed, exp_q holds 1 while q follows d.
      obs_en = 1'b0;
      tick(6);
      check("hold_chk_cnt", chk_cnt, 1);
      check("hold_exp_q", exp_q, 1);
      obs_d = 1'b0; obs_q = 1'b0;
      tick(10);
      check("hold_pulses", err_pulses, 2);
      check("hold_err_cnt", err_cnt, 1);
      check("hold_sticky", err_sticky, 1);
      check("hold_exp_q2", exp_q, 1);
      obs_d = 1'b1; obs_q = 1'b1;
      tick(6);
      check("hold_match_pulses", err_pulses, 2);
      check("hold_match_chk", chk_cnt, 3);

      // q alone flips while checking: not a change, so it is a mismatch.
      obs_q = 1'b0;
      tick(4);
      check("qonly_pulses", err_pulses, 3);
      check("qonly_err_cnt", err_cnt, 2);
      check("qonly_chk_cnt", chk_cnt, 3);

      // 300 mismatched intervals drive both counters into saturation.
      for (int n = 0; n < 300; n++) begin
         obs_d = ~obs_d;
         tick(6);
      end
      check("sat_err_cnt", err_cnt, 255);
      check("sat_chk_cnt", chk_cnt, 255);
      check("sat_sticky", err_sticky, 1);
      check("sat_pulses", err_pulses, 303);

      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr2_err_cnt", err_cnt, 0);
      check("clr2_sticky", err_sticky, 0);
      check("clr2_chk_cnt", chk_cnt, 0);

      // clr on the same edge as an error event.
      obs_d = ~obs_d;
      tick(4);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clrerr_err", err, 1);
      check("clrerr_err_cnt", err_cnt, 1);
      check("clrerr_sticky", err_sticky, 1);
      check("clrerr_chk_cnt", chk_cnt, 0);
      tick(2);

      // clr on the same edge as a check event.
      obs_d = ~obs_d;
      tick(3);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clrchk_chk_cnt", chk_cnt, 1);
      check("clrchk_err_cnt", err_cnt, 0);
      check("clrchk_sticky", err_sticky, 0);
      tick(1);
      check("clrchk_err", err, 1);
      check("clrchk_err_cnt2", err_cnt, 1);
      tick(1);

      // Asynchronous reset while a mismatch is pending in CHECK.
      obs_d = ~obs_d;
      tick(4);
      rstn = 1'b0;
      #1;
      check("arst_err", err, 0);
      check("arst_sticky", err_sticky, 0);
      check("arst_err_cnt", err_cnt, 0);
      check("arst_chk_cnt", chk_cnt, 0);
      check("arst_exp_q", exp_q, 0);
      tick(1);
      check("arst_err_late", err, 0);
      check("arst_pulses", err_pulses, 305);
      rstn = 1'b1;
      tick(6);
      check("post_chk_cnt", chk_cnt, 1);
      check("post_err_cnt", err_cnt, 0);
      check("post_pulses", err_pulses, 305);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
